serial_word_tx: RTL and testbench
=================================

Name: serial_word_tx

Overview:
- Parallel-to-serial transmitter: accepts a WIDTH-bit word on a valid/ready handshake and shifts it out LSB-first, one bit per clock.
- Drives the serial input of the bit-serial two's-complement convertor. Its frame_start pulse is the per-word restart for that convertor.
- Optionally performs on-the-fly serial negation itself, so a word can leave already two's-complemented.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- GAP, 1: idle cycles inserted after each frame; legal range 0..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- din  in  WIDTH  parallel word to send.
- din_valid  in  1  din holds a word to send.
- din_ready  out  1  the block accepts din on this edge; a word transfers when din_valid and din_ready are both 1 at a rising edge.
- sout  out  1  serial data bit, LSB first.
- sout_valid  out  1  sout carries a frame bit this cycle.
- frame_start  out  1  high with bit 0 of each frame.
- frame_last  out  1  high with bit WIDTH-1 of each frame.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: while reset=0, the following hold asynchronously: state=IDLE, shift register=0, bit counter=0, sout=0, sout_valid=0, frame_start=0, frame_last=0, busy=0, din_ready=0.
- din_ready is forced to 0 while reset is low.
- Outputs: sout, sout_valid, frame_start and frame_last are registered. din_ready and busy are decoded from state and reset.
- FSM states: IDLE, SHIFT, GAP.
- IDLE: din_ready=1.
  - On a handshake: latch din, clear counter, go to SHIFT.
  - Latency: bit 0 appears on sout in the cycle after the accepting edge, with sout_valid=1 and frame_start=1.
- SHIFT: one bit per cycle, bits 0..WIDTH-1. sout_valid=1 for exactly WIDTH consecutive cycles.
  - frame_start is high only with bit 0; frame_last is high only with bit WIDTH-1.
  - After the last bit: go to GAP if GAP>0, else to IDLE.
  - din_ready=0 in SHIFT, except on the last-bit cycle when GAP=0.
- Back-to-back (GAP=0): a handshake on the last-bit cycle reloads the shift register. Bit 0 of the new word follows bit WIDTH-1 with no bubble; frame_start=1 on that cycle.
- GAP: exactly GAP cycles with sout=0, sout_valid=0 and din_ready=0, then IDLE.
- Stall: if din_valid=0 in IDLE, the block stays in IDLE indefinitely with all outputs 0 except din_ready=1.
- din is don't-care except at the handshake edge; changes to din mid-frame do not affect the frame in flight.
- Reset mid-frame: the frame is abandoned immediately and no partial remainder is sent after release.
  - The first edge after release sees IDLE with din_ready=1.
  - The next frame begins with frame_start=1.
- WIDTH=2: frame_start and frame_last fall on adjacent cycles.
- Frame duration: WIDTH cycles; period WIDTH+GAP cycles per word, or WIDTH+GAP+1 if din_valid arrives only in IDLE.

Optional Feature:
- Macro: TWOS_COMP_EN.
- Defined: a seen_one flag is cleared at each frame start.
  - Each transmitted bit b is sent as b while seen_one=0, else as ~b.
  - seen_one is set after the first raw bit equal to 1, so the stream carries -din mod 2^WIDTH.
  - din=0 sends all zeros; din=100..0 sends itself unchanged.
  - The flag is cleared by reset and on every handshake.
- Undefined: raw bits are sent and no seen_one logic is synthesised.
- Handshake and framing timing are identical in both builds.

Test Plan:
- Reset then WIDTH=8, GAP=1, din=8'h2C held valid one cycle -> sout over 8 cycles = 0,0,1,1,0,1,0,0; frame_start on cycle 1, frame_last on cycle 8; one gap cycle; din_ready back to 1 on cycle 10.
- Same word with TWOS_COMP_EN -> sout = 0,0,1,0,1,0,1,1 (8'hD4); din=8'h00 -> all zeros; din=8'h80 -> 0,0,0,0,0,0,0,1.
- GAP=0, din_valid held high with words 8'hA5 then 8'h3C -> 16 consecutive sout_valid cycles; frame_start on cycles 1 and 9; no bubble.
- reset driven low on bit 3 of 8'hFF, asynchronously between edges -> sout, sout_valid and busy drop to 0 at once; after release, 8'h01 sends 1,0,0,0,0,0,0,0 with frame_start=1.
- din_valid low for 20 cycles after reset -> sout_valid stays 0 and din_ready=1 throughout; din toggled mid-frame -> transmitted bits match the latched word.
- WIDTH=2, GAP=3, din=2'b10 -> sout 0,1; frame_start and frame_last on adjacent cycles; 3 idle cycles, then din_ready=1.

Source files
------------

// File: rtl/serial_word_tx.sv
// -----------------------------------------------------------------------------
// serial_word_tx
//
// Parallel-to-serial transmitter. A WIDTH-bit word is accepted on a
// valid/ready handshake and shifted out LSB-first, one bit per clock, followed
// by GAP idle cycles. frame_start marks bit 0 of every frame and serves as the
// per-word restart for a downstream bit-serial two's-complement convertor.
//
// Optional build macro:
//   TWOS_COMP_EN - when defined, the word is negated on the fly so the serial
//                  stream carries -din mod 2^WIDTH. Framing and handshake
//                  timing are identical in both builds.
//
// Parameters:
//   WIDTH  word width in bits (2..32)
//   GAP    idle cycles inserted after each frame (0..15)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   din          parallel word to send
//   din_valid    din holds a word to send
//   din_ready    word accepted on this edge when din_valid is also high
//   sout         serial data bit, LSB first (registered)
//   sout_valid   sout carries a frame bit this cycle (registered)
//   frame_start  high with bit 0 of each frame (registered)
//   frame_last   high with bit WIDTH-1 of each frame (registered)
//   busy         FSM is not idle
// -----------------------------------------------------------------------------
module serial_word_tx #(
   parameter int WIDTH = 8,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame_start,
   output logic             frame_last,
   output logic             busy
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [3:0]       GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);
   localparam bit               HAS_GAP  = (GAP > 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP
   } state_t;

   state_t           state_q, state_d;
   // Holds the bits still to be sent; bit 0 of a word goes straight to sout_q.
   logic [WIDTH-1:0] shift_q, shift_d;
   // Index of the bit currently presented on sout.
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       gap_q, gap_d;
   logic             sout_q, sout_d;
   logic             sout_valid_q, sout_valid_d;
   logic             frame_start_q, frame_start_d;
   logic             frame_last_q, frame_last_d;
`ifdef TWOS_COMP_EN
   // Set once a raw 1 has been sent; every later bit is inverted.
   logic             seen_one_q, seen_one_d;
`endif

   logic last_bit;
   logic accept;

   assign last_bit  = (state_q == ST_SHIFT) && (cnt_q == LAST_BIT);
   // With no gap the last-bit cycle can take the next word, giving
   // back-to-back frames without a bubble.
   assign din_ready = reset && ((state_q == ST_IDLE) || (!HAS_GAP && last_bit));
   assign busy      = reset && (state_q != ST_IDLE);
   assign accept    = din_valid && din_ready;

   assign sout        = sout_q;
   assign sout_valid  = sout_valid_q;
   assign frame_start = frame_start_q;
   assign frame_last  = frame_last_q;

   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      cnt_d         = cnt_q;
      gap_d         = gap_q;
      sout_d        = 1'b0;
      sout_valid_d  = 1'b0;
      frame_start_d = 1'b0;
      frame_last_d  = 1'b0;
`ifdef TWOS_COMP_EN
      seen_one_d    = seen_one_q;
`endif

      if (accept) begin
         state_d       = ST_SHIFT;
         shift_d       = din >> 1;
         cnt_d         = '0;
         sout_valid_d  = 1'b1;
         frame_start_d = 1'b1;
         // Bit 0 is never inverted: the flag restarts with each word.
         sout_d        = din[0];
`ifdef TWOS_COMP_EN
         seen_one_d    = din[0];
`endif
      end else begin
         case (state_q)
            ST_SHIFT: begin
               if (last_bit) begin
                  state_d = HAS_GAP ? ST_GAP : ST_IDLE;
                  gap_d   = '0;
               end else begin
                  shift_d      = shift_q >> 1;
                  cnt_d        = cnt_q + CNT_W'(1);
                  sout_valid_d = 1'b1;
                  frame_last_d = (cnt_d == LAST_BIT);
`ifdef TWOS_COMP_EN
                  sout_d       = shift_q[0] ^ seen_one_q;
                  seen_one_d   = seen_one_q | shift_q[0];
`else
                  sout_d       = shift_q[0];
`endif
               end
            end
            ST_GAP: begin
               if (gap_q == GAP_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  gap_d = gap_q + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         shift_q       <= '0;
         cnt_q         <= '0;
         gap_q         <= '0;
         sout_q        <= 1'b0;
         sout_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_last_q  <= 1'b0;
`ifdef TWOS_COMP_EN
         seen_one_q    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         shift_q       <= shift_d;
         cnt_q         <= cnt_d;
         gap_q         <= gap_d;
         sout_q        <= sout_d;
         sout_valid_q  <= sout_valid_d;
         frame_start_q <= frame_start_d;
         frame_last_q  <= frame_last_d;
`ifdef TWOS_COMP_EN
         seen_one_q    <= seen_one_d;
`endif
      end
   end

endmodule

// File: tb/tb_serial_word_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_word_tx
//
// Self-checking bench for serial_word_tx. Three instances cover the
// configurations of interest: u0 (WIDTH=8, GAP=1), u1 (WIDTH=8, GAP=0,
// back-to-back streaming) and u2 (WIDTH=2, GAP=3). Expected serial words come
// from tx_word(): the word itself, or its negation when TWOS_COMP_EN is set.
// -----------------------------------------------------------------------------
module tb_serial_word_tx;

   logic       clk;
   logic       reset;
   logic [7:0] din_a [3];
   logic [2:0] val_a;
   wire  [2:0] rdy_a, so_a, sov_a, fs_a, fl_a, busy_a;

   int checks = 0;
   int errors = 0;

   serial_word_tx #(.WIDTH(8), .GAP(1)) u0 (
      .clk(clk), .reset(reset), .din(din_a[0]), .din_valid(val_a[0]),
      .din_ready(rdy_a[0]), .sout(so_a[0]), .sout_valid(sov_a[0]),
      .frame_start(fs_a[0]), .frame_last(fl_a[0]), .busy(busy_a[0]));

   serial_word_tx #(.WIDTH(8), .GAP(0)) u1 (
      .clk(clk), .reset(reset), .din(din_a[1]), .din_valid(val_a[1]),
      .din_ready(rdy_a[1]), .sout(so_a[1]), .sout_valid(sov_a[1]),
      .frame_start(fs_a[1]), .frame_last(fl_a[1]), .busy(busy_a[1]));

   serial_word_tx #(.WIDTH(2), .GAP(3)) u2 (
      .clk(clk), .reset(reset), .din(din_a[2][1:0]), .din_valid(val_a[2]),
      .din_ready(rdy_a[2]), .sout(so_a[2]), .sout_valid(sov_a[2]),
      .frame_start(fs_a[2]), .frame_last(fl_a[2]), .busy(busy_a[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Word that should appear on the serial line for input w.
   function automatic logic [7:0] tx_word(input logic [7:0] w, input int width);
      logic [7:0] m;
      m = 8'hFF >> (8 - width);
`ifdef TWOS_COMP_EN
      return (~w + 8'd1) & m;
`else
      return w & m;
`endif
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One complete frame on instance k, starting at a falling edge with k idle.
   task automatic frame(input int k, input int width, input int gap,
                        input logic [7:0] w, input logic [7:0] exp, input string nm);
      logic [7:0] got;
      int         tmo;
      int         bad;
      got = '0;
      tmo = 0;
      bad = 0;
      while (rdy_a[k] !== 1'b1 && tmo < 50) begin
         @(negedge clk);
         tmo++;
      end
      chk({nm, "_ready"}, 64'(rdy_a[k]), 64'd1);
      din_a[k] = w;
      val_a[k] = 1'b1;
      @(negedge clk);
      val_a[k] = 1'b0;
      for (int i = 0; i < width; i++) begin
         din_a[k] = 8'($urandom);          // mid-frame din must not matter
         if (sov_a[k] !== 1'b1 || fs_a[k] !== (i == 0) || fl_a[k] !== (i == width - 1) ||
             rdy_a[k] !== (gap == 0 && i == width - 1) || busy_a[k] !== 1'b1)
            bad++;
         got[i] = so_a[k];
         @(negedge clk);
      end
      chk({nm, "_framing"}, 64'(bad), 64'd0);
      chk({nm, "_bits"}, 64'(got), 64'(exp));
      bad = 0;
      for (int g = 0; g < gap; g++) begin
         if (sov_a[k] !== 1'b0 || so_a[k] !== 1'b0 || rdy_a[k] !== 1'b0 || busy_a[k] !== 1'b1)
            bad++;
         @(negedge clk);
      end
      chk({nm, "_gap"}, 64'(bad), 64'd0);
      chk({nm, "_idle"}, 64'({rdy_a[k], busy_a[k], sov_a[k]}), 64'b100);
   endtask

   // Streams every word of stream_q through u1 with din_valid held high.
   logic [7:0] stream_q[$];

   task automatic run_stream(input string nm);
      int          n;
      int          idx;
      int          nval;
      int          first;
      int          last;
      logic        acc;
      logic [63:0] got_bits, exp_bits, fs_m, fs_e, fl_m, fl_e;
      n = stream_q.size();
      idx = 0; nval = 0; first = -1; last = -1;
      got_bits = '0; exp_bits = '0; fs_m = '0; fs_e = '0; fl_m = '0; fl_e = '0;
      for (int j = 0; j < n; j++) begin
         exp_bits = exp_bits | (64'(tx_word(stream_q[j], 8)) << (8 * j));
         fs_e[8 * j]     = 1'b1;
         fl_e[8 * j + 7] = 1'b1;
      end
      din_a[1] = stream_q[0];
      val_a[1] = 1'b1;
      for (int c = 0; c < n * 8 + 6; c++) begin
         if (sov_a[1] === 1'b1) begin
            if (first < 0) first = c;
            last = c;
            if (nval < 64) begin
               got_bits[nval] = so_a[1];
               fs_m[nval]     = fs_a[1];
               fl_m[nval]     = fl_a[1];
            end
            nval++;
         end
         acc = rdy_a[1] && val_a[1];
         @(posedge clk);
         #1;
         if (acc) begin
            idx++;
            if (idx < n) din_a[1] = stream_q[idx];
            else begin
               val_a[1] = 1'b0;
               din_a[1] = 8'($urandom);
            end
         end
         @(negedge clk);
      end
      chk({nm, "_valid_count"}, 64'(nval), 64'(n * 8));
      chk({nm, "_no_bubble"}, 64'(last - first + 1), 64'(n * 8));
      chk({nm, "_bits"}, got_bits, exp_bits);
      chk({nm, "_frame_start"}, fs_m, fs_e);
      chk({nm, "_frame_last"}, fl_m, fl_e);
   endtask

   typedef struct {
      logic [7:0] din;
      logic [7:0] exp;
      string      nm;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int         bad;
      logic [7:0] w;

`ifdef TWOS_COMP_EN
      tbl[0] = '{8'h2C, 8'hD4, "tbl_2c"};
      tbl[1] = '{8'h00, 8'h00, "tbl_00"};
      tbl[2] = '{8'h80, 8'h80, "tbl_80"};
      tbl[3] = '{8'hFF, 8'h01, "tbl_ff"};
      tbl[4] = '{8'h01, 8'hFF, "tbl_01"};
`else
      tbl[0] = '{8'h2C, 8'h2C, "tbl_2c"};
      tbl[1] = '{8'h00, 8'h00, "tbl_00"};
      tbl[2] = '{8'h80, 8'h80, "tbl_80"};
      tbl[3] = '{8'hFF, 8'hFF, "tbl_ff"};
      tbl[4] = '{8'h01, 8'h01, "tbl_01"};
`endif

      reset = 1'b0;
      val_a = '0;
      for (int k = 0; k < 3; k++) din_a[k] = 8'h00;

      // Reset state
      #2;
      for (int k = 0; k < 3; k++)
         chk($sformatf("reset_state_u%0d", k),
             64'({so_a[k], sov_a[k], fs_a[k], fl_a[k], busy_a[k], rdy_a[k]}), 64'd0);
      #10 reset = 1'b1;
      @(negedge clk);

      // Stall: nothing offered for 20 cycles
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         din_a[0] = 8'($urandom);
         for (int k = 0; k < 3; k++)
            if ({so_a[k], sov_a[k], fs_a[k], fl_a[k], busy_a[k], rdy_a[k]} !== 6'b000001) bad++;
         @(negedge clk);
      end
      chk("stall_idle", 64'(bad), 64'd0);

      // Directed table on u0
      for (int i = 0; i < 5; i++) frame(0, 8, 1, tbl[i].din, tbl[i].exp, tbl[i].nm);

      // Random words on u0 against the model
      for (int i = 0; i < 30; i++) begin
         w = 8'($urandom);
         frame(0, 8, 1, w, tx_word(w, 8), $sformatf("rand_u0_%0d", i));
      end

      // WIDTH=2, GAP=3
      frame(2, 2, 3, 8'h02, 8'h02, "w2_10");
      for (int i = 0; i < 8; i++) begin
         w = 8'($urandom);
         frame(2, 2, 3, w, tx_word(w, 2), $sformatf("rand_u2_%0d", i));
      end

      // GAP=0 back-to-back
      stream_q = '{8'hA5, 8'h3C};
      run_stream("b2b_a5_3c");
      stream_q.delete();
      for (int i = 0; i < 6; i++) stream_q.push_back(8'($urandom));
      run_stream("b2b_rand");

      // Asynchronous reset in the middle of a frame
      din_a[0] = 8'hFF;
      val_a[0] = 1'b1;
      @(negedge clk);
      val_a[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mid_frame_active", 64'({sov_a[0], busy_a[0]}), 64'b11);
      #2 reset = 1'b0;
      #1;
      chk("rst_async_outputs", 64'({so_a[0], sov_a[0], fs_a[0], fl_a[0]}), 64'd0);
      chk("rst_async_busy", 64'(busy_a[0]), 64'd0);
      chk("rst_async_ready", 64'(rdy_a[0]), 64'd0);
      @(negedge clk);
      @(negedge clk);
      #3 reset = 1'b1;
      @(negedge clk);
      chk("rst_release_idle", 64'({rdy_a[0], busy_a[0], sov_a[0]}), 64'b100);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (sov_a[0] !== 1'b0) bad++;
      end
      chk("rst_no_remainder", 64'(bad), 64'd0);
      frame(0, 8, 1, 8'h01, tx_word(8'h01, 8), "post_reset_01");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
